// File: rtl/ist_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ist_fetch_ctrl_if
// Brief    : Stream handshakes between ist_fetch_ctrl and its FIFOs
//            (leaf in, memory request out, memory response in, triangle out).
// Revision : 1.0 - initial release
// ============================================================================
interface ist_fetch_ctrl_if #(
  parameter int RID_W = 8,
  parameter int CID_W = 4,
  parameter int NT_W  = 3,
  parameter int IDX_W = 16
);
  logic                          leaf_stream_empty_n;
  logic                          leaf_stream_read;
  logic [IDX_W+NT_W+RID_W-1:0]   leaf_stream_dout;

  logic                          ist_mem_req_stream_full_n;
  logic                          ist_mem_req_stream_write;
  logic [IDX_W+NT_W+RID_W-1:0]   ist_mem_req_stream_din;

  logic                          ist_mem_resp_stream_empty_n;
  logic                          ist_mem_resp_stream_read;
  logic [RID_W-1:0]              ist_mem_resp_stream_dout;

  logic                          trig_stream_full_n;
  logic                          trig_stream_write;
  logic [1+NT_W+CID_W+RID_W-1:0] trig_stream_din;

  modport master (
    input  leaf_stream_empty_n, leaf_stream_dout,
    output leaf_stream_read,
    input  ist_mem_req_stream_full_n,
    output ist_mem_req_stream_write, ist_mem_req_stream_din,
    input  ist_mem_resp_stream_empty_n, ist_mem_resp_stream_dout,
    output ist_mem_resp_stream_read,
    input  trig_stream_full_n,
    output trig_stream_write, trig_stream_din
  );

  modport slave (
    output leaf_stream_empty_n, leaf_stream_dout,
    input  leaf_stream_read,
    output ist_mem_req_stream_full_n,
    input  ist_mem_req_stream_write, ist_mem_req_stream_din,
    output ist_mem_resp_stream_empty_n, ist_mem_resp_stream_dout,
    input  ist_mem_resp_stream_read,
    output trig_stream_full_n,
    input  trig_stream_write, trig_stream_din
  );
endinterface
`default_nettype wire

// File: rtl/ist_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ist_fetch_ctrl
// Brief    : Forwards leaf work items as IST memory requests, tracks one leaf
//            per context slot, and streams one triangle command per loaded tri.
// Revision : 1.0 - initial release
// ============================================================================
module ist_fetch_ctrl #(
  parameter int RID_W = 8,
  parameter int TID_W = 2,
  parameter int CID_W = 4,
  parameter int NT_W  = 3,
  parameter int IDX_W = 16
) (
  input  wire               clk,
  input  wire               arst_n,
  ist_fetch_ctrl_if.master  bus,
  output logic              zero_leaf_drop,
  output logic              err_unexpected_resp
);

  localparam int c_num_cid = 2**CID_W;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ITER = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [c_num_cid-1:0] r_busy;
  logic [NT_W-1:0]      r_nt_tab [c_num_cid];
  logic [NT_W-1:0]      r_count;
  logic [NT_W-1:0]      r_n;
  logic [CID_W-1:0]     r_cid;
  logic [RID_W-1:0]     r_rid;
  logic                 r_err;

  logic [CID_W-1:0]     w_cid_in;
  logic [NT_W-1:0]      w_nt_in;
  logic                 w_nt_zero;
  logic                 w_leaf_read;
  logic                 w_req_accept;
  logic [CID_W-1:0]     w_cid_resp;
  logic                 w_resp_read;
  logic                 w_load;
  logic                 w_err_set;
  logic                 w_trig_write;
  logic                 w_last;
  logic                 w_clr;
  logic [c_num_cid-1:0] w_set_mask;
  logic [c_num_cid-1:0] w_clr_mask;

  // Request path: a busy slot stalls the whole leaf FIFO (head-of-line)
  assign w_cid_in     = bus.leaf_stream_dout[TID_W +: CID_W];
  assign w_nt_in      = bus.leaf_stream_dout[RID_W +: NT_W];
  assign w_nt_zero    = (w_nt_in == '0);
  assign w_leaf_read  = arst_n & bus.leaf_stream_empty_n & ~r_busy[w_cid_in]
                        & (w_nt_zero | bus.ist_mem_req_stream_full_n);
  assign w_req_accept = w_leaf_read & ~w_nt_zero;

  assign bus.leaf_stream_read         = w_leaf_read;
  assign bus.ist_mem_req_stream_write = w_req_accept;
  assign bus.ist_mem_req_stream_din   = bus.leaf_stream_dout;
  assign zero_leaf_drop               = w_leaf_read & w_nt_zero;

  assign w_cid_resp = bus.ist_mem_resp_stream_dout[TID_W +: CID_W];
  assign w_last     = (r_count == r_n - NT_W'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_resp_read  = 1'b0;
    w_trig_write = 1'b0;
    w_load       = 1'b0;
    w_err_set    = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_resp_read = arst_n & bus.ist_mem_resp_stream_empty_n;
        if (w_resp_read) begin
          if (r_busy[w_cid_resp]) begin
            w_load      = 1'b1;
            w_state_nxt = ST_ITER;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_ITER: begin
        w_trig_write = arst_n & bus.trig_stream_full_n;
        if (w_trig_write && w_last) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ist_mem_resp_stream_read = w_resp_read;
  assign bus.trig_stream_write        = w_trig_write;
  assign bus.trig_stream_din          = {w_last, r_count, r_cid, r_rid};
  assign err_unexpected_resp          = r_err;

  // Set and clear never target the same slot, so the masks compose freely
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_req_accept) w_set_mask[w_cid_in] = 1'b1;
    if (w_clr)        w_clr_mask[r_cid]    = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_busy  <= '0;
      r_count <= '0;
      r_n     <= '0;
      r_cid   <= '0;
      r_rid   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < c_num_cid; i++) r_nt_tab[i] <= '0;
    end else begin
      r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
      if (w_req_accept) r_nt_tab[w_cid_in] <= w_nt_in;
      if (w_err_set)    r_err <= 1'b1;
      if (w_load) begin
        r_cid   <= w_cid_resp;
        r_rid   <= bus.ist_mem_resp_stream_dout;
        r_n     <= r_nt_tab[w_cid_resp];
        r_count <= '0;
      end else if (w_trig_write) begin
        r_count <= r_count + NT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ist_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ist_fetch_ctrl
// Brief    : Directed self-checking bench for ist_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ist_fetch_ctrl;

  logic clk;
  logic arst_n;
  logic zero_leaf_drop;
  logic err_unexpected_resp;
  int   n_assert = 0;
  int   n_fail   = 0;

  ist_fetch_ctrl_if #(.RID_W(8), .CID_W(4), .NT_W(3), .IDX_W(16)) bus ();

  ist_fetch_ctrl #(
    .RID_W(8), .TID_W(2), .CID_W(4), .NT_W(3), .IDX_W(16)
  ) dut (
    .clk                 (clk),
    .arst_n              (arst_n),
    .bus                 (bus.master),
    .zero_leaf_drop      (zero_leaf_drop),
    .err_unexpected_resp (err_unexpected_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n                          = 1'b0;
    bus.leaf_stream_empty_n         = 1'b0;
    bus.leaf_stream_dout            = '0;
    bus.ist_mem_req_stream_full_n   = 1'b0;
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    bus.ist_mem_resp_stream_dout    = '0;
    bus.trig_stream_full_n          = 1'b0;

    // Reset: strobes gated even with data everywhere
    @(negedge clk);
    bus.leaf_stream_empty_n         = 1'b1;
    bus.leaf_stream_dout            = {16'h0040, 3'd3, 8'h15};
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_req_stream_full_n   = 1'b1;
    bus.trig_stream_full_n          = 1'b1;
    #1;
    chk("rst_leaf_read",  bus.leaf_stream_read, 0);
    chk("rst_req_write",  bus.ist_mem_req_stream_write, 0);
    chk("rst_resp_read",  bus.ist_mem_resp_stream_read, 0);
    chk("rst_trig_write", bus.trig_stream_write, 0);
    chk("rst_err",        err_unexpected_resp, 0);
    chk("rst_drop",       zero_leaf_drop, 0);

    // Leaf 0x15 n=3 echoed as a request the same cycle
    @(negedge clk);
    arst_n = 1'b1;
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("leaf1_read",      bus.leaf_stream_read, 1);
    chk("leaf1_req_write", bus.ist_mem_req_stream_write, 1);
    chk("leaf1_req_din",   bus.ist_mem_req_stream_din, {16'h0040, 3'd3, 8'h15});
    chk("leaf1_resp_read", bus.ist_mem_resp_stream_read, 0);

    // cid 5 busy: leaf 0x16 blocked; response 0x15 popped
    @(negedge clk);
    bus.leaf_stream_dout            = {16'h0050, 3'd2, 8'h16};
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_resp_stream_dout    = 8'h15;
    #1;
    chk("blk_leaf_read", bus.leaf_stream_read, 0);
    chk("blk_req_write", bus.ist_mem_req_stream_write, 0);
    chk("resp15_read",   bus.ist_mem_resp_stream_read, 1);
    chk("resp15_trig0",  bus.trig_stream_write, 0);

    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("j1_c0_write", bus.trig_stream_write, 1);
    chk("j1_c0_din",   bus.trig_stream_din, 16'h0515);
    chk("j1_c0_blk",   bus.leaf_stream_read, 0);
    @(negedge clk); #1;
    chk("j1_c1_write", bus.trig_stream_write, 1);
    chk("j1_c1_din",   bus.trig_stream_din, 16'h1515);
    @(negedge clk); #1;
    chk("j1_c2_write", bus.trig_stream_write, 1);
    chk("j1_c2_din",   bus.trig_stream_din, 16'hA515);
    chk("j1_c2_blk",   bus.leaf_stream_read, 0);

    // Cycle after last: busy[5] cleared, leaf 0x16 accepted
    @(negedge clk); #1;
    chk("leaf2_read",    bus.leaf_stream_read, 1);
    chk("leaf2_req_din", bus.ist_mem_req_stream_din, {16'h0050, 3'd2, 8'h16});
    chk("j1_done_trig",  bus.trig_stream_write, 0);

    // Zero-trig leaf dropped
    @(negedge clk);
    bus.leaf_stream_dout = {16'h0000, 3'd0, 8'h08};
    #1;
    chk("drop_read",      bus.leaf_stream_read, 1);
    chk("drop_req_write", bus.ist_mem_req_stream_write, 0);
    chk("drop_pulse",     zero_leaf_drop, 1);

    // busy[2] stayed 0: a cid-2 leaf is accepted straight away
    @(negedge clk);
    bus.leaf_stream_dout = {16'h0011, 3'd1, 8'h0A};
    #1;
    chk("drop_pulse_end", zero_leaf_drop, 0);
    chk("cid2_read",      bus.leaf_stream_read, 1);
    chk("cid2_req_write", bus.ist_mem_req_stream_write, 1);

    // Job 0x16 (n=2)
    @(negedge clk);
    bus.leaf_stream_empty_n         = 1'b0;
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_resp_stream_dout    = 8'h16;
    #1;
    chk("resp16_read", bus.ist_mem_resp_stream_read, 1);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("j2_c0_din", bus.trig_stream_din, 16'h0516);
    @(negedge clk); #1;
    chk("j2_c1_din", bus.trig_stream_din, 16'h9516);

    // Back-pressure job: rid 0x1C (cid 7), n=5
    @(negedge clk);
    bus.leaf_stream_empty_n = 1'b1;
    bus.leaf_stream_dout    = {16'h0100, 3'd5, 8'h1C};
    #1;
    chk("leaf1c_read", bus.leaf_stream_read, 1);
    chk("j2_end_trig", bus.trig_stream_write, 0);
    @(negedge clk);
    bus.leaf_stream_empty_n         = 1'b0;
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_resp_stream_dout    = 8'h1C;
    #1;
    chk("resp1c_read", bus.ist_mem_resp_stream_read, 1);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("j3_c0_din", bus.trig_stream_din, 16'h071C);
    @(negedge clk); #1;
    chk("j3_c1_din", bus.trig_stream_din, 16'h171C);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.trig_stream_full_n = 1'b0;
      #1;
      chk("stall_write", bus.trig_stream_write, 0);
      chk("stall_din",   bus.trig_stream_din, 16'h271C);
    end
    @(negedge clk);
    bus.trig_stream_full_n = 1'b1;
    #1;
    chk("j3_c2_write", bus.trig_stream_write, 1);
    chk("j3_c2_din",   bus.trig_stream_din, 16'h271C);
    @(negedge clk); #1;
    chk("j3_c3_din",   bus.trig_stream_din, 16'h371C);
    @(negedge clk); #1;
    chk("j3_c4_write", bus.trig_stream_write, 1);
    chk("j3_c4_din",   bus.trig_stream_din, 16'hC71C);

    // Unexpected response for idle cid 12
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_resp_stream_dout    = 8'h30;
    #1;
    chk("j3_end_trig",  bus.trig_stream_write, 0);
    chk("resp30_read",  bus.ist_mem_resp_stream_read, 1);
    chk("err_before",   err_unexpected_resp, 0);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("err_set",      err_unexpected_resp, 1);
    chk("err_no_trig",  bus.trig_stream_write, 0);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_resp_stream_dout    = 8'h0A;
    #1;
    chk("err_idle_read", bus.ist_mem_resp_stream_read, 1);
    chk("err_sticky",    err_unexpected_resp, 1);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("j4_write", bus.trig_stream_write, 1);
    chk("j4_din",   bus.trig_stream_din, 16'h820A);

    // Reset mid-job: rid 0x24 (cid 9), n=7, abort at count 2
    @(negedge clk);
    bus.leaf_stream_empty_n = 1'b1;
    bus.leaf_stream_dout    = {16'h0200, 3'd7, 8'h24};
    #1;
    chk("leaf24_read", bus.leaf_stream_read, 1);
    @(negedge clk);
    bus.leaf_stream_empty_n         = 1'b0;
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.ist_mem_resp_stream_dout    = 8'h24;
    #1;
    chk("resp24_read", bus.ist_mem_resp_stream_read, 1);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("j5_c0_din", bus.trig_stream_din, 16'h0924);
    @(negedge clk); #1;
    chk("j5_c1_din", bus.trig_stream_din, 16'h1924);
    @(negedge clk); #1;
    chk("j5_c2_write", bus.trig_stream_write, 1);
    chk("j5_c2_din",   bus.trig_stream_din, 16'h2924);
    #1;
    arst_n                          = 1'b0;
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    bus.leaf_stream_empty_n         = 1'b1;
    bus.leaf_stream_dout            = {16'h0300, 3'd1, 8'h24};
    #1;
    chk("arst_trig_write", bus.trig_stream_write, 0);
    chk("arst_resp_read",  bus.ist_mem_resp_stream_read, 0);
    chk("arst_leaf_read",  bus.leaf_stream_read, 0);
    chk("arst_err_clr",    err_unexpected_resp, 0);
    @(negedge clk);
    arst_n                          = 1'b1;
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("post_rst_leaf_read", bus.leaf_stream_read, 1);
    chk("post_rst_trig",      bus.trig_stream_write, 0);
    chk("post_rst_err",       err_unexpected_resp, 0);
    @(negedge clk);
    bus.leaf_stream_empty_n         = 1'b0;
    bus.ist_mem_resp_stream_empty_n = 1'b1;
    #1;
    chk("post_rst_resp_read", bus.ist_mem_resp_stream_read, 1);
    @(negedge clk);
    bus.ist_mem_resp_stream_empty_n = 1'b0;
    #1;
    chk("j6_write", bus.trig_stream_write, 1);
    chk("j6_din",   bus.trig_stream_din, 16'h8924);
    @(negedge clk); #1;
    chk("j6_end_trig", bus.trig_stream_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
